display_7seg_multiplexado: RTL and testbench

- Parametrised successor to the team's four-digit display encoder for the Nexys 3 DPWM board.
- Selects one of two binary measurements (frecuencia or corriente), converts it to BCD with a sequential shift-add-3 (double-dabble) engine, and holds the result in a display buffer.
- Time-multiplexes N_DIGITS common-anode digits at a programmable refresh rate.
- Adds leading-zero blanking, per-digit decimal points, an overflow indication and a busy flag. Segment decoding is internal; no external memory block is used.

---
 rtl/display_7seg_multiplexado.sv | 192 +++++++++++++++++++
 tb/tb_display_7seg_multiplexado.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/display_7seg_multiplexado.sv
// Multiplexed N-digit 7-segment display driver: picks one of two binary inputs,
// converts it to BCD with a sequential double-dabble engine and scans the digits.
module display_7seg_multiplexado #(
    parameter int DATA_W     = 10,
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   frecuencia,
    input  logic [DATA_W-1:0]   corriente,
    input  logic                control,
    input  logic                actualizar,
    input  logic [N_DIGITS-1:0] punto,
    output logic [N_DIGITS-1:0] selec_digito,
    output logic [7:0]          numero_cod,
    output logic                ocupado,
    output logic                desborde
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [N_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [7:0]          SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    state_t                r_state, w_next;
    logic [DATA_W-1:0]     r_shift;
    logic [BCD_W-1:0]      r_bcd, r_buf, w_adj;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ovf, r_desborde, r_ocupado;
    logic [PRE_W-1:0]      r_presc;
    logic [IDX_W-1:0]      r_idx;
    logic [N_DIGITS-1:0]   r_sel, w_sel, w_blank;
    logic [7:0]            r_seg, w_seg;
    logic [6:0]            w_seg7;
    logic [3:0]            w_nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next-state logic of the conversion controller
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (actualizar) w_next = ST_CONV;
                else            w_next = ST_IDLE;
            end
            ST_CONV: begin
                if (r_cnt == CNT_W'(1)) w_next = ST_LOAD;
                else                    w_next = ST_CONV;
            end
            ST_LOAD: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ocupado <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ocupado <= (w_next != ST_IDLE);
        end
    end

    // Add-3 correction on every BCD nibble ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else                         w_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
    end

    // Conversion datapath and display buffer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= {DATA_W{1'b0}};
            r_bcd      <= {BCD_W{1'b0}};
            r_buf      <= {BCD_W{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_ovf      <= 1'b0;
            r_desborde <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (actualizar) begin
                        r_shift <= control ? frecuencia : corriente;
                        r_bcd   <= {BCD_W{1'b0}};
                        r_ovf   <= 1'b0;
                        r_cnt   <= CNT_W'(DATA_W);
                    end
                end
                ST_CONV: begin
                    // A bit leaving the top nibble means the value no longer fits
                    r_bcd   <= {w_adj[BCD_W-2:0], r_shift[DATA_W-1]};
                    r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                    r_ovf   <= r_ovf | w_adj[BCD_W-1];
                    r_cnt   <= r_cnt - CNT_W'(1);
                end
                ST_LOAD: begin
                    r_buf      <= r_bcd;
                    r_desborde <= r_ovf;
                end
                default: ;
            endcase
        end
    end

    // Refresh prescaler and digit scan index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= {PRE_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
        end else if (r_presc == PRE_W'(SCAN_DIV - 1)) begin
            r_presc <= {PRE_W{1'b0}};
            if (r_idx == IDX_W'(N_DIGITS - 1)) r_idx <= {IDX_W{1'b0}};
            else                               r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Leading-zero mask: a digit blanks when it and all digits above are zero
    always_comb begin
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_blank      = {N_DIGITS{1'b0}};
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            w_zero_above = w_zero_above & (r_buf[4*i +: 4] == 4'd0);
            w_blank[i]   = w_zero_above & (BLANK_LZ != 0);
        end
    end

    // Segment pattern and enable for the digit currently scanned
    always_comb begin
        w_nib = r_buf[4*r_idx +: 4];
        if (r_desborde)          w_seg7 = 7'h40;
        else if (w_blank[r_idx]) w_seg7 = 7'h00;
        else                     w_seg7 = seg_decode(w_nib);
        w_seg = {punto[r_idx], w_seg7};
        w_sel = {{(N_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    end

    // Output register: enable and segments always update together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= SEL_OFF;
            r_seg <= SEG_OFF;
        end else if (ACTIVE_LOW != 0) begin
            r_sel <= ~w_sel;
            r_seg <= ~w_seg;
        end else begin
            r_sel <= w_sel;
            r_seg <= w_seg;
        end
    end

    assign selec_digito = r_sel;
    assign numero_cod   = r_seg;
    assign ocupado      = r_ocupado;
    assign desborde     = r_desborde;

endmodule

// File: tb/tb_display_7seg_multiplexado.sv
// Directed bench for display_7seg_multiplexado: a 4-digit and a 2-digit instance
// share stimulus; expected scan patterns are queued and popped as digits appear.
module tb_display_7seg_multiplexado;

    localparam int SCAN_DIV = 4;
    localparam logic [6:0] SEG_TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [7:0] sel;
        logic [7:0] seg;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] frecuencia = 10'd0;
    logic [9:0] corriente = 10'd0;
    logic       control = 1'b0;
    logic       actualizar = 1'b0;
    logic [3:0] punto = 4'b0000;
    logic [3:0] sel1;
    logic [7:0] seg1;
    logic       ocupado1, desborde1;
    logic [1:0] sel2;
    logic [7:0] seg2;
    logic       ocupado2, desborde2;

    exp_t sbq[$];
    int   n_total = 0;
    int   n_pass = 0;
    int   n_fail = 0;
    int   busy;

    always #5 clock = ~clock;

    display_7seg_multiplexado #(.DATA_W(10), .N_DIGITS(4), .SCAN_DIV(SCAN_DIV),
                                .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .frecuencia(frecuencia), .corriente(corriente),
        .control(control), .actualizar(actualizar), .punto(punto),
        .selec_digito(sel1), .numero_cod(seg1), .ocupado(ocupado1), .desborde(desborde1));

    display_7seg_multiplexado #(.DATA_W(10), .N_DIGITS(2), .SCAN_DIV(SCAN_DIV),
                                .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .frecuencia(frecuencia), .corriente(corriente),
        .control(control), .actualizar(actualizar), .punto(punto[1:0]),
        .selec_digito(sel2), .numero_cod(seg2), .ocupado(ocupado2), .desborde(desborde2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Active-low segment byte the display should show for digit d of val
    function automatic logic [7:0] exp_seg(input int val, input int nd, input int d, input logic dp);
        int p = 1;
        int lim = 1;
        logic [7:0] s;
        for (int k = 0; k < d; k++) p = p * 10;
        for (int k = 0; k < nd; k++) lim = lim * 10;
        if (val >= lim)             s = {dp, 7'h40};
        else if (d > 0 && val < p)  s = {dp, 7'h00};
        else                        s = {dp, SEG_TBL[(val / p) % 10]};
        return ~s;
    endfunction

    task automatic push_expect(input int val, input int nd, input logic [3:0] pun);
        exp_t e;
        logic [7:0] mask;
        mask = (8'd1 << nd) - 8'd1;
        for (int d = 0; d < nd; d++) begin
            e.sel = (~(8'd1 << d)) & mask;
            e.seg = exp_seg(val, nd, d, pun[d]);
            sbq.push_back(e);
        end
    endtask

    function automatic logic [7:0] obs_sel(input int which);
        if (which == 1) return {4'b0000, sel1};
        else            return {6'b000000, sel2};
    endfunction

    function automatic logic [7:0] obs_seg(input int which);
        if (which == 1) return seg1;
        else            return seg2;
    endfunction

    task automatic scan_check(input int which, input int nd, input string tag);
        logic [7:0] tgt;
        int w;
        exp_t e;
        tgt = (~8'd1) & ((8'd1 << nd) - 8'd1);
        w = 0;
        while (obs_sel(which) !== tgt && w < 64) begin
            @(negedge clock);
            w++;
        end
        chk({tag, "_sync"}, 32'(w < 64), 32'd1);
        for (int d = 0; d < nd; d++) begin
            e = sbq.pop_front();
            chk($sformatf("%s_sel%0d", tag, d), 32'(obs_sel(which)), 32'(e.sel));
            chk($sformatf("%s_seg%0d", tag, d), 32'(obs_seg(which)), 32'(e.seg));
            repeat (SCAN_DIV) @(negedge clock);
        end
    endtask

    task automatic run_conv(input int second_at, input logic [9:0] second_val, output int nbusy);
        actualizar = 1'b1;
        @(negedge clock);
        actualizar = 1'b0;
        nbusy = 0;
        while (ocupado1 === 1'b1 && nbusy < 40) begin
            nbusy++;
            if (nbusy == second_at) begin
                actualizar = 1'b1;
                corriente  = second_val;
            end
            @(negedge clock);
            actualizar = 1'b0;
        end
    endtask

    initial begin
        int quiet;
        // Reset held for three cycles
        repeat (3) @(negedge clock);
        chk("rst_sel", 32'(sel1), 32'hF);
        chk("rst_seg", 32'(seg1), 32'hFF);
        chk("rst_busy", 32'(ocupado1), 32'd0);
        chk("rst_ovf", 32'(desborde1), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_sel", 32'(sel1), 32'hE);
        chk("rel_seg", 32'(seg1), 32'hC0);
        chk("rel_busy", 32'(ocupado1), 32'd0);
        chk("rel_ovf", 32'(desborde1), 32'd0);

        // corriente = 987
        control = 1'b0; corriente = 10'd987; punto = 4'b0000;
        push_expect(987, 4, punto);
        run_conv(0, 10'd0, busy);
        chk("busy_987", 32'(busy), 32'd11);
        chk("ovf_987", 32'(desborde1), 32'd0);
        scan_check(1, 4, "v987");

        // frecuencia = 5 with a decimal point on digit 1
        control = 1'b1; frecuencia = 10'd5; punto = 4'b0010;
        push_expect(5, 4, punto);
        run_conv(0, 10'd0, busy);
        chk("busy_5", 32'(busy), 32'd11);
        scan_check(1, 4, "v5dp");

        // 1023: fits in four digits, overflows two
        control = 1'b0; corriente = 10'd1023; punto = 4'b0000;
        push_expect(1023, 4, punto);
        push_expect(1023, 2, punto);
        run_conv(0, 10'd0, busy);
        chk("ovf4_1023", 32'(desborde1), 32'd0);
        chk("ovf2_1023", 32'(desborde2), 32'd1);
        scan_check(1, 4, "v1023");
        scan_check(2, 2, "v1023n2");

        // Second strobe during CONV is ignored
        corriente = 10'd321;
        push_expect(321, 4, punto);
        run_conv(3, 10'd654, busy);
        chk("busy_ignore", 32'(busy), 32'd11);
        quiet = 0;
        repeat (3) begin
            @(negedge clock);
            if (ocupado1 !== 1'b0) quiet++;
        end
        chk("no_requeue", 32'(quiet), 32'd0);
        scan_check(1, 4, "v321");

        // Reset in the middle of a conversion
        corriente = 10'd777;
        actualizar = 1'b1;
        @(negedge clock);
        actualizar = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_busy_pre", 32'(ocupado1), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(ocupado1), 32'd0);
        chk("mid_sel", 32'(sel1), 32'hF);
        chk("mid_seg", 32'(seg1), 32'hFF);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_busy", 32'(ocupado1), 32'd0);
        chk("post_ovf", 32'(desborde1), 32'd0);
        push_expect(0, 4, punto);
        scan_check(1, 4, "vrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
